// File: rtl/rom_word_fetch.sv
// Instruction-fetch adapter in front of a 256x16 synchronous-read ROM.
// Assembles two halfword reads into a little-endian word and keeps the last fetched word.
module rom_word_fetch #(
  parameter int ADDR_W   = 32,
  parameter int ROM_AW   = 8,
  parameter int CACHE_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              rom_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are
  // both high; valid never depends on ready, and payload is held until the transfer.

  localparam int WI_W = ROM_AW - 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_CAP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t              state_q;
  logic [WI_W-1:0]     word_q;
  logic [WI_W-1:0]     tag_q;
  logic                buf_valid_q;
  logic [31:0]         buf_data_q;
  logic [15:0]         lo_q;
  logic [31:0]         resp_data_q;
  logic                resp_err_q;
  logic                rom_en_q;
  logic [ROM_AW-1:0]   rom_addr_q;

  logic [WI_W-1:0]     word_d;
  logic                err_d;
  logic                hit_d;

  always_comb begin
    word_d = req_addr[ROM_AW:2];
    err_d  = (req_addr[1:0] != 2'b00) || ((req_addr >> (ROM_AW + 1)) != '0);
    hit_d  = (CACHE_EN != 0) && buf_valid_q && (word_d == tag_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      tag_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      lo_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            word_q <= word_d;
            if (err_d) begin
              resp_err_q  <= 1'b1;
              resp_data_q <= '0;
              state_q     <= S_OUT;
            end else if (hit_d) begin
              resp_err_q  <= 1'b0;
              resp_data_q <= buf_data_q;
              state_q     <= S_OUT;
            end else begin
              // Address the low halfword now so the ROM samples it at the end of LO.
              rom_en_q   <= 1'b1;
              rom_addr_q <= {word_d, 1'b0};
              state_q    <= S_LO;
            end
          end
        end
        S_LO: begin
          rom_addr_q <= {word_q, 1'b1};
          state_q    <= S_HI;
        end
        S_HI: begin
          lo_q     <= rom_data;
          rom_en_q <= 1'b0;
          state_q  <= S_CAP;
        end
        S_CAP: begin
          resp_data_q <= {rom_data, lo_q};
          resp_err_q  <= 1'b0;
          if (CACHE_EN != 0) begin
            buf_valid_q <= 1'b1;
            tag_q       <= word_q;
            buf_data_q  <= {rom_data, lo_q};
          end
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (resp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_OUT);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign rom_en     = rom_en_q;
  assign rom_addr   = rom_addr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_word_fetch.sv
// Bench for rom_word_fetch: ROM model, request driver, expected-response queue,
// and a second instance with the last-word buffer disabled.
module tb_rom_word_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, rom_en;
  logic [31:0] req_addr, resp_data;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [2:0]  dbg_state;

  logic        req_valid_n, req_ready_n, resp_valid_n, resp_ready_n, resp_err_n, rom_en_n;
  logic [31:0] req_addr_n, resp_data_n;
  logic [7:0]  rom_addr_n;
  logic [15:0] rom_data_n;
  logic [2:0]  dbg_state_n;

  logic [15:0] mem [256];
  logic [32:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        mdl_valid = 1'b0;
  logic [6:0]  mdl_tag = '0;

  always #5 clk = ~clk;

  rom_word_fetch #(.ADDR_W(32), .ROM_AW(8), .CACHE_EN(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .dbg_state(dbg_state)
  );

  rom_word_fetch #(.ADDR_W(32), .ROM_AW(8), .CACHE_EN(0)) dut_nc (
    .clk(clk), .reset(reset), .req_valid(req_valid_n), .req_ready(req_ready_n),
    .req_addr(req_addr_n), .resp_valid(resp_valid_n), .resp_ready(resp_ready_n),
    .resp_data(resp_data_n), .resp_err(resp_err_n), .rom_en(rom_en_n),
    .rom_addr(rom_addr_n), .rom_data(rom_data_n), .dbg_state(dbg_state_n)
  );

  always @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];
  always @(posedge clk) if (rom_en_n) rom_data_n <= mem[rom_addr_n];

  // Reference model: pushes the expected {err,data} and predicts latency / ROM reads.
  task automatic predict(input logic [31:0] addr, output int lat, output int cnt);
    logic       err;
    logic [6:0] w;
    err = (addr[1:0] != 2'b00) || (addr[31:9] != 23'd0);
    w   = addr[8:2];
    if (err) begin
      exp_q.push_back({1'b1, 32'h0});
      lat = 1; cnt = 0;
    end else begin
      exp_q.push_back({1'b0, mem[{w, 1'b1}], mem[{w, 1'b0}]});
      if (mdl_valid && mdl_tag == w) begin
        lat = 1; cnt = 0;
      end else begin
        lat = 4; cnt = 2;
        mdl_valid = 1'b1;
        mdl_tag   = w;
      end
    end
  endtask

  // Drives one request and reports what the DUT did; consumes the response if resp_ready.
  task automatic send(input logic [31:0] addr, output int lat, output logic [32:0] got,
                      output int cnt, output logic [7:0] a0, output logic [7:0] a1);
    req_addr  = addr;
    req_valid = 1'b1;
    for (int g = 0; g < 20 && !req_ready; g++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; cnt = 0; a0 = 8'hxx; a1 = 8'hxx;
    for (int c = 0; c < 20; c++) begin
      if (rom_en) begin
        if (cnt == 0) a0 = rom_addr; else a1 = rom_addr;
        cnt++;
      end
      if (resp_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    got = {resp_err, resp_data};
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err got=%b exp=0", resp_err); end
    total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL rst_resp_data got=%h exp=0", resp_data); end
    total++; if (rom_en !== 1'b0) begin bad++; $display("FAIL rst_rom_en got=%b exp=0", rom_en); end
    total++; if (rom_addr !== 8'h0) begin bad++; $display("FAIL rst_rom_addr got=%h exp=0", rom_addr); end
    total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_miss;
    int el, ec, lat, cnt; logic [32:0] got, exp; logic [7:0] a0, a1;
    predict(32'h0, el, ec);
    send(32'h0, lat, got, cnt, a0, a1);
    exp = exp_q.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL miss_lat got=%0d exp=%0d", lat, el); end
    total++; if (cnt !== ec) begin bad++; $display("FAIL miss_rom_cnt got=%0d exp=%0d", cnt, ec); end
    total++; if (a0 !== 8'd0 || a1 !== 8'd1) begin bad++; $display("FAIL miss_rom_addr got=%0d,%0d exp=0,1", a0, a1); end
    total++; if (got !== exp) begin bad++; $display("FAIL miss_data got=%h exp=%h", got, exp); end
    total++; if (got !== 33'h0_00100093) begin bad++; $display("FAIL miss_word got=%h exp=000100093", got); end
  endtask

  task automatic test_back_to_back;
    int el, ec, lat, cnt; logic [32:0] got, exp; logic [7:0] a0, a1;
    predict(32'h0, el, ec);
    send(32'h0, lat, got, cnt, a0, a1);
    exp = exp_q.pop_front();
    total++; if (lat !== 1) begin bad++; $display("FAIL hit_lat got=%0d exp=1", lat); end
    total++; if (cnt !== 0) begin bad++; $display("FAIL hit_rom_cnt got=%0d exp=0", cnt); end
    total++; if (got !== exp) begin bad++; $display("FAIL hit_data got=%h exp=%h", got, exp); end
  endtask

  task automatic test_errors;
    int el, ec, lat, cnt; logic [32:0] got, exp; logic [7:0] a0, a1;
    logic [31:0] addrs [3];
    addrs[0] = 32'h2; addrs[1] = 32'h200; addrs[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      predict(addrs[i], el, ec);
      send(addrs[i], lat, got, cnt, a0, a1);
      exp = exp_q.pop_front();
      total++; if (lat !== el) begin bad++; $display("FAIL err_lat[%0d] got=%0d exp=%0d", i, lat, el); end
      total++; if (cnt !== ec) begin bad++; $display("FAIL err_rom_cnt[%0d] got=%0d exp=%0d", i, cnt, ec); end
      total++; if (got !== exp) begin bad++; $display("FAIL err_resp[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_last_word;
    int el, ec, lat, cnt; logic [32:0] got, exp; logic [7:0] a0, a1;
    predict(32'h1FC, el, ec);
    send(32'h1FC, lat, got, cnt, a0, a1);
    exp = exp_q.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL last_lat got=%0d exp=%0d", lat, el); end
    total++; if (a0 !== 8'd254 || a1 !== 8'd255) begin bad++; $display("FAIL last_rom_addr got=%0d,%0d exp=254,255", a0, a1); end
    total++; if (got !== 33'h0_DEADBEEF) begin bad++; $display("FAIL last_data got=%h exp=%h", got, exp); end
  endtask

  task automatic test_backpressure;
    int el, ec, lat, cnt; logic [32:0] got, exp; logic [7:0] a0, a1;
    resp_ready = 1'b0;
    predict(32'h10, el, ec);
    send(32'h10, lat, got, cnt, a0, a1);
    exp = exp_q.pop_front();
    total++; if (lat !== el) begin bad++; $display("FAIL bp_lat got=%0d exp=%0d", lat, el); end
    for (int i = 0; i < 10; i++) begin
      total++; if (resp_valid !== 1'b1 || {resp_err, resp_data} !== exp) begin
        bad++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", i, resp_valid, {resp_err, resp_data}, exp); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got=ready%b/valid%b exp=ready1/valid0", req_ready, resp_valid); end
  endtask

  task automatic test_reset_mid;
    int el, ec, lat, cnt; logic [32:0] got, exp; logic [7:0] a0, a1;
    predict(32'h40, el, ec);
    send(32'h40, lat, got, cnt, a0, a1);
    exp = exp_q.pop_front();
    total++; if (got !== exp) begin bad++; $display("FAIL rmid_prefetch got=%h exp=%h", got, exp); end
    req_addr = 32'h80; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (dbg_state !== 3'd2 || rom_en !== 1'b1 || rom_addr !== 8'h41) begin
      bad++; $display("FAIL rmid_in_hi got=st%0d/en%b/a%h exp=st2/en1/a41", dbg_state, rom_en, rom_addr); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mdl_valid = 1'b0;
    total++; if (dbg_state !== 3'd0 || rom_en !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_abort got=st%0d/en%b/v%b/r%b exp=st0/en0/v0/r1", dbg_state, rom_en, resp_valid, req_ready); end
    predict(32'h40, el, ec);
    send(32'h40, lat, got, cnt, a0, a1);
    exp = exp_q.pop_front();
    total++; if (lat !== el || cnt !== ec) begin bad++; $display("FAIL rmid_refetch got=lat%0d/cnt%0d exp=lat%0d/cnt%0d", lat, cnt, el, ec); end
    total++; if (got !== exp) begin bad++; $display("FAIL rmid_data got=%h exp=%h", got, exp); end
  endtask

  task automatic test_random;
    int el, ec, lat, cnt, kind; logic [32:0] got, exp; logic [7:0] a0, a1;
    logic [31:0] addr, last_good;
    last_good = 32'h0;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
      else if (kind == 1) addr = {23'd0, 7'($urandom_range(0, 127)), 2'b00} | (32'd1 << $urandom_range(9, 31));
      else if (kind < 5)  addr = last_good;
      else                addr = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      if (kind > 1) last_good = addr;
      predict(addr, el, ec);
      send(addr, lat, got, cnt, a0, a1);
      exp = exp_q.pop_front();
      total++; if (lat !== el || cnt !== ec) begin
        bad++; $display("FAIL rnd_timing[%0d] addr=%h got=lat%0d/cnt%0d exp=lat%0d/cnt%0d", i, addr, lat, cnt, el, ec); end
      total++; if (got !== exp) begin bad++; $display("FAIL rnd_data[%0d] addr=%h got=%h exp=%h", i, addr, got, exp); end
      if (ec == 2) begin
        total++; if (a0 !== {addr[8:2], 1'b0} || a1 !== {addr[8:2], 1'b1}) begin
          bad++; $display("FAIL rnd_rom_addr[%0d] got=%h,%h exp=%h,%h", i, a0, a1, {addr[8:2], 1'b0}, {addr[8:2], 1'b1}); end
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_no_cache;
    int lat, cnt; logic [32:0] got;
    for (int k = 0; k < 2; k++) begin
      total++; if (req_ready_n !== 1'b1) begin bad++; $display("FAIL nc_ready[%0d] got=%b exp=1", k, req_ready_n); end
      req_addr_n = 32'h0; req_valid_n = 1'b1;
      @(posedge clk); #1;
      req_valid_n = 1'b0;
      lat = 1; cnt = 0;
      for (int c = 0; c < 20; c++) begin
        if (rom_en_n) cnt++;
        if (resp_valid_n) break;
        @(posedge clk); #1;
        lat++;
      end
      got = {resp_err_n, resp_data_n};
      total++; if (lat !== 4 || cnt !== 2) begin bad++; $display("FAIL nc_timing[%0d] got=lat%0d/cnt%0d exp=lat4/cnt2", k, lat, cnt); end
      total++; if (got !== 33'h0_00100093) begin bad++; $display("FAIL nc_data[%0d] got=%h exp=000100093", k, got); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0093; mem[1] = 16'h0010;
    mem[254] = 16'hBEEF; mem[255] = 16'hDEAD;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    req_valid_n = 1'b0; req_addr_n = '0; resp_ready_n = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_miss();
    test_back_to_back();
    test_errors();
    test_last_word();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_no_cache();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
